// File: rtl/nfca_rx_pkg.sv
// nfca_rx_pkg: shared status/state types and timing constants for the NFC-A receive session
package nfca_rx_pkg;
    typedef enum logic [2:0] {
        RX_OK       = 3'd0,
        RX_COL      = 3'd1,
        RX_ERR      = 3'd2,
        RX_PERR     = 3'd3,
        RX_TIMEOUT  = 3'd4,
        RX_OVERFLOW = 3'd5
    } rx_status_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;
    localparam int FDT_CYCLES    = 7032;
    localparam int GUARD_DEF     = 4096;
    localparam int TIMEOUT_DEF   = 406800;
    localparam int MAX_BYTES_DEF = 64;
    // Error outranks collision, collision outranks a parity failure seen earlier in the frame.
    function automatic rx_status_t end_status(input logic err, input logic full, input logic col,
                                              input logic perr);
        return (err || full) ? RX_ERR : col ? RX_COL : perr ? RX_PERR : RX_OK;
    endfunction
endpackage

// File: rtl/nfca_rx_byte_asm.sv
// nfca_rx_byte_asm: packs received bits LSB-first into bytes with optional odd-parity check
module nfca_rx_byte_asm (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       par,
    input  logic       bit_en,
    input  logic       din,
    input  logic       flush,
    output logic       byte_en,
    output logic [7:0] data,
    output logic [3:0] bits,
    output logic       perr,
    output logic       emit,
    output logic       perr_now,
    output logic       data_bit,
    output logic       empty,
    output logic       pend_full,
    output logic       flush_emit
);
    logic [3:0] n, n_b, bits_a;
    logic [7:0] shift, s_a;
    logic       full_emit;
    assign empty     = n == 4'd0;
    assign data_bit  = bit_en && n != 4'd8;
    assign pend_full = n_b == 4'd8;
    // Apply the incoming bit first, then an end-of-frame flush of whatever remains in the group.
    always_comb begin
        n_b       = n;
        s_a       = shift;
        perr_now  = 1'b0;
        full_emit = 1'b0;
        if (bit_en && n == 4'd8) begin
            perr_now  = din == ^shift;
            full_emit = 1'b1;
            n_b       = 4'd0;
        end else if (bit_en) begin
            s_a[n[2:0]] = din;
            full_emit   = !par && n == 4'd7;
            n_b         = full_emit ? 4'd0 : n + 4'd1;
        end
        flush_emit = flush && n_b != 4'd0;
        emit       = full_emit || flush_emit;
        bits_a     = flush_emit ? n_b : 4'd8;
    end
    // Register the emitted byte one clock after its completing bit and restart the group.
    always_ff @(posedge clk) begin
        if (rst) begin
            n       <= '0;
            shift   <= '0;
            byte_en <= 1'b0;
            data    <= '0;
            bits    <= '0;
            perr    <= 1'b0;
        end else begin
            byte_en <= emit;
            n       <= (clear || emit) ? 4'd0 : n_b;
            shift   <= (clear || emit) ? 8'd0 : s_a;
            if (emit) begin
                data <= s_a;
                bits <= bits_a;
                perr <= perr_now;
            end
        end
    end
endmodule

// File: rtl/nfca_rx_session.sv
// nfca_rx_session: sequences one PICC->PCD receive session (guard, timeout, packing, end status)
module nfca_rx_session #(
    parameter int GUARD_CYCLES   = 4096,
    parameter int TIMEOUT_CYCLES = 406800,
    parameter int MAX_BYTES      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_done,
    input  logic       abort,
    input  logic       parity_en,
    output logic       rx_on,
    input  logic       rx_bit_en,
    input  logic       rx_bit,
    input  logic       rx_end,
    input  logic       rx_end_col,
    input  logic       rx_end_err,
    output logic       rx_byte_en,
    output logic [7:0] rx_byte,
    output logic [3:0] rx_byte_bits,
    output logic       rx_byte_perr,
    output logic       rx_done,
    output logic [2:0] rx_status,
    output logic [9:0] rx_nbits,
    output logic       busy
);
    import nfca_rx_pkg::*;
    localparam int CMAX = GUARD_CYCLES > TIMEOUT_CYCLES ? GUARD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam int BW   = $clog2(MAX_BYTES + 1);
    state_t        state, state_n;
    rx_status_t    status;
    logic [CW-1:0] cnt;
    logic [BW-1:0] byte_cnt;
    logic [9:0]    nbits;
    logic          par, perr_seen, end_q;
    logic          start, live, ovf, bit_go, end_go, tmo;
    logic          emit, perr_now, data_bit, empty, pend_full, flush_emit;
    assign start  = state == S_IDLE && tx_done && !abort;
    assign live   = (state == S_WAIT || state == S_RECV) && !end_q && !abort;
    assign ovf    = live && rx_bit_en && byte_cnt == BW'(MAX_BYTES) && empty;
    assign bit_go = live && rx_bit_en && !ovf;
    assign end_go = live && rx_end && !ovf;
    assign tmo    = live && state == S_WAIT && !rx_bit_en && !rx_end
                    && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign rx_status = status;
    assign rx_nbits  = nbits;
    nfca_rx_byte_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .par       (par),
        .bit_en    (bit_go),
        .din       (rx_bit),
        .flush     (end_go),
        .byte_en   (rx_byte_en),
        .data      (rx_byte),
        .bits      (rx_byte_bits),
        .perr      (rx_byte_perr),
        .emit      (emit),
        .perr_now  (perr_now),
        .data_bit  (data_bit),
        .empty     (empty),
        .pend_full (pend_full),
        .flush_emit(flush_emit)
    );
    // State register.
    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_n;
    end
    // Next state; a flushed partial byte holds off DONE by one cycle so the byte precedes rx_done.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:         state_n = tx_done ? S_GUARD : S_IDLE;
            S_GUARD:        state_n = cnt == CW'(GUARD_CYCLES - 1) ? S_WAIT : S_GUARD;
            S_WAIT, S_RECV: state_n = (end_q || ovf || tmo) ? S_DONE
                                    : end_go ? (flush_emit ? S_RECV : S_DONE)
                                    : bit_go ? S_RECV : state;
            default:        state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end
    // Outputs decoded from state.
    always_comb begin
        rx_on   = state == S_WAIT || state == S_RECV;
        rx_done = state == S_DONE;
        busy    = state != S_IDLE;
    end
    // Shared guard/timeout timer, byte and bit counters, sticky parity error and final status.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            byte_cnt  <= '0;
            nbits     <= '0;
            status    <= RX_OK;
            par       <= 1'b0;
            perr_seen <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            cnt   <= (state_n == state && (state == S_GUARD || state == S_WAIT)) ? cnt + 1'b1 : '0;
            end_q <= end_go && flush_emit;
            if (start) begin
                par       <= parity_en;
                byte_cnt  <= '0;
                nbits     <= '0;
                perr_seen <= 1'b0;
                status    <= RX_OK;
            end else begin
                byte_cnt  <= byte_cnt + BW'(emit);
                nbits     <= nbits + 10'(data_bit);
                perr_seen <= perr_seen | perr_now;
                status    <= ovf ? RX_OVERFLOW
                           : end_go ? end_status(rx_end_err, pend_full, rx_end_col, perr_seen | perr_now)
                           : tmo ? RX_TIMEOUT : status;
            end
        end
    end
endmodule

// File: tb/tb_nfca_rx_session.sv
// tb_nfca_rx_session: directed checks of guard, timeout, packing, parity, collision, overflow, abort
module tb_nfca_rx_session;
    logic       clk = 1'b0, rst = 1'b1, tx_done = 1'b0, abort = 1'b0, parity_en = 1'b0;
    logic       rx_bit_en = 1'b0, rx_bit = 1'b0, rx_end = 1'b0, rx_end_col = 1'b0, rx_end_err = 1'b0;
    logic       rx_on, rx_byte_en, rx_byte_perr, rx_done, busy;
    logic [7:0] rx_byte;
    logic [3:0] rx_byte_bits;
    logic [2:0] rx_status;
    logic [9:0] rx_nbits;
    int         checks = 0, errors = 0, cyc = 0, done_cnt = 0;
    logic [7:0] q_data[$];
    logic [3:0] q_bits[$];
    logic       q_perr[$];

    nfca_rx_session #(.GUARD_CYCLES(16), .TIMEOUT_CYCLES(100), .MAX_BYTES(2)) dut (
        .clk(clk), .rst(rst), .tx_done(tx_done), .abort(abort), .parity_en(parity_en),
        .rx_on(rx_on), .rx_bit_en(rx_bit_en), .rx_bit(rx_bit), .rx_end(rx_end),
        .rx_end_col(rx_end_col), .rx_end_err(rx_end_err), .rx_byte_en(rx_byte_en),
        .rx_byte(rx_byte), .rx_byte_bits(rx_byte_bits), .rx_byte_perr(rx_byte_perr),
        .rx_done(rx_done), .rx_status(rx_status), .rx_nbits(rx_nbits), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rx_byte_en) begin
            q_data.push_back(rx_byte);
            q_bits.push_back(rx_byte_bits);
            q_perr.push_back(rx_byte_perr);
        end
        if (rx_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_q;
        q_data.delete();
        q_bits.delete();
        q_perr.delete();
    endtask
    task automatic start(input logic p);
        parity_en = p;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
        parity_en = 1'b0;
    endtask
    task automatic wait_on(output int k);
        k = 0;
        while (!rx_on && k < 200) begin tick; k++; end
    endtask
    task automatic wait_done(output int k);
        k = 0;
        while (!rx_done && k < 500) begin tick; k++; end
    endtask
    task automatic send_bit(input logic b, input logic e, input logic c);
        rx_bit_en = 1'b1; rx_bit = b; rx_end = e; rx_end_col = c;
        tick;
        rx_bit_en = 1'b0; rx_bit = 1'b0; rx_end = 1'b0; rx_end_col = 1'b0;
    endtask
    // mode 0: no parity bit, 1: correct odd parity, 2: inverted parity
    task automatic send_byte(input logic [7:0] d, input int mode);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, 1'b0);
        if (mode != 0) send_bit((~^d) ^ (mode == 2), 1'b0, 1'b0);
    endtask
    task automatic send_end(input logic c, input logic e);
        rx_end = 1'b1; rx_end_col = c; rx_end_err = e;
        tick;
        rx_end = 1'b0; rx_end_col = 1'b0; rx_end_err = 1'b0;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if ({rx_on, busy, rx_done, rx_byte_en} !== 4'b0) begin errors++; $display("FAIL reset_in got %b exp 0000", {rx_on, busy, rx_done, rx_byte_en}); end
        rst = 1'b0;
        tick;
        checks++; if ({rx_on, busy, rx_done, rx_byte_en, rx_status, rx_nbits} !== 17'b0) begin errors++; $display("FAIL reset_out got %h exp 0", {rx_on, busy, rx_done, rx_byte_en, rx_status, rx_nbits}); end
    endtask

    task automatic test_basic;
        int k;
        clear_q();
        start(1'b1);
        checks++; if (busy !== 1'b1 || rx_on !== 1'b0) begin errors++; $display("FAIL guard_state got busy=%b rx_on=%b exp 1 0", busy, rx_on); end
        wait_on(k);
        checks++; if (k !== 16) begin errors++; $display("FAIL guard_len got %0d exp 16", k); end
        send_byte(8'h04, 1);
        send_byte(8'h00, 1);
        send_end(1'b0, 1'b0);
        wait_done(k);
        checks++; if (rx_done !== 1'b1 || rx_status !== 3'd0 || rx_nbits !== 10'd16) begin errors++; $display("FAIL basic_done got done=%b st=%0d nb=%0d exp 1 0 16", rx_done, rx_status, rx_nbits); end
        tick;
        checks++; if (rx_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse got done=%b busy=%b exp 0 0", rx_done, busy); end
        checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL basic_nbytes got %0d exp 2", q_data.size()); end
        else begin
            checks++; if ({q_data[0], q_bits[0], q_perr[0]} !== {8'h04, 4'd8, 1'b0}) begin errors++; $display("FAIL basic_b0 got %h/%0d/%b exp 04/8/0", q_data[0], q_bits[0], q_perr[0]); end
            checks++; if ({q_data[1], q_bits[1], q_perr[1]} !== {8'h00, 4'd8, 1'b0}) begin errors++; $display("FAIL basic_b1 got %h/%0d/%b exp 00/8/0", q_data[1], q_bits[1], q_perr[1]); end
        end
    endtask

    task automatic test_timeout;
        int k, t0;
        start(1'b1);
        t0 = cyc;
        wait_done(k);
        checks++; if (cyc - t0 !== 116) begin errors++; $display("FAIL tmo_time got %0d exp 116", cyc - t0); end
        checks++; if (rx_status !== 3'd4 || rx_nbits !== 10'd0 || rx_on !== 1'b0) begin errors++; $display("FAIL tmo_status got st=%0d nb=%0d on=%b exp 4 0 0", rx_status, rx_nbits, rx_on); end
        tick;
        checks++; if (rx_on !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_after got on=%b busy=%b exp 0 0", rx_on, busy); end
    endtask

    task automatic test_parity_err;
        int k;
        clear_q();
        start(1'b1);
        wait_on(k);
        send_byte(8'h93, 2);
        send_end(1'b0, 1'b0);
        wait_done(k);
        checks++; if (rx_status !== 3'd3 || rx_nbits !== 10'd8) begin errors++; $display("FAIL perr_status got st=%0d nb=%0d exp 3 8", rx_status, rx_nbits); end
        tick;
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL perr_nbytes got %0d exp 1", q_data.size()); end
        else begin
            checks++; if ({q_data[0], q_bits[0], q_perr[0]} !== {8'h93, 4'd8, 1'b1}) begin errors++; $display("FAIL perr_byte got %h/%0d/%b exp 93/8/1", q_data[0], q_bits[0], q_perr[0]); end
        end
    endtask

    task automatic test_collision;
        int k;
        clear_q();
        start(1'b1);
        wait_on(k);
        send_byte(8'h93, 1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        checks++; if ({rx_byte_en, rx_done, rx_byte, rx_byte_bits} !== {1'b1, 1'b0, 8'h16, 4'd5}) begin errors++; $display("FAIL col_partial got en=%b done=%b %h/%0d exp 1 0 16/5", rx_byte_en, rx_done, rx_byte, rx_byte_bits); end
        tick;
        checks++; if (rx_done !== 1'b1 || rx_status !== 3'd1 || rx_nbits !== 10'd13) begin errors++; $display("FAIL col_done got done=%b st=%0d nb=%0d exp 1 1 13", rx_done, rx_status, rx_nbits); end
        tick;
        checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL col_nbytes got %0d exp 2", q_data.size()); end
        else begin
            checks++; if ({q_data[0], q_bits[0], q_perr[0]} !== {8'h93, 4'd8, 1'b0}) begin errors++; $display("FAIL col_b0 got %h/%0d/%b exp 93/8/0", q_data[0], q_bits[0], q_perr[0]); end
        end
    endtask

    task automatic test_overflow;
        int k;
        clear_q();
        start(1'b0);
        wait_on(k);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_bit(1'b1, 1'b0, 1'b0);
        checks++; if (rx_on !== 1'b0 || rx_done !== 1'b1) begin errors++; $display("FAIL ovf_stop got on=%b done=%b exp 0 1", rx_on, rx_done); end
        checks++; if (rx_status !== 3'd5 || rx_nbits !== 10'd16) begin errors++; $display("FAIL ovf_status got st=%0d nb=%0d exp 5 16", rx_status, rx_nbits); end
        tick;
        checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL ovf_nbytes got %0d exp 2", q_data.size()); end
        else begin
            checks++; if ({q_data[0], q_data[1], q_perr[1]} !== {8'hA5, 8'h3C, 1'b0}) begin errors++; $display("FAIL ovf_bytes got %h %h perr=%b exp a5 3c 0", q_data[0], q_data[1], q_perr[1]); end
        end
    endtask

    task automatic test_abort_reset;
        int k, dn;
        clear_q();
        start(1'b0);
        wait_on(k);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        dn = done_cnt;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || rx_on !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b on=%b exp 0 0", busy, rx_on); end
        repeat (20) tick;
        checks++; if (done_cnt !== dn || q_data.size() !== 0) begin errors++; $display("FAIL abort_quiet got done=%0d bytes=%0d exp %0d 0", done_cnt, q_data.size(), dn); end
        abort = 1'b1; tx_done = 1'b1;
        tick;
        abort = 1'b0; tx_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_tx got busy=%b exp 0", busy); end
        start(1'b0);
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || rx_on !== 1'b0 || rx_done !== 1'b0) begin errors++; $display("FAIL rst_guard got busy=%b on=%b done=%b exp 0 0 0", busy, rx_on, rx_done); end
        start(1'b0);
        wait_on(k);
        checks++; if (k !== 16) begin errors++; $display("FAIL restart_guard got %0d exp 16", k); end
        send_byte(8'h5A, 0);
        send_end(1'b0, 1'b0);
        wait_done(k);
        checks++; if (rx_status !== 3'd0 || rx_nbits !== 10'd8) begin errors++; $display("FAIL restart_done got st=%0d nb=%0d exp 0 8", rx_status, rx_nbits); end
        tick;
        checks++; if (q_data.size() !== 1 || q_data[0] !== 8'h5A || q_bits[0] !== 4'd8) begin errors++; $display("FAIL restart_byte got n=%0d %h exp 1 5a", q_data.size(), q_data.size() > 0 ? q_data[0] : 8'h00); end
        checks++; if (done_cnt !== 6) begin errors++; $display("FAIL done_total got %0d exp 6", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_parity_err();
        test_collision();
        test_overflow();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
